uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter, the successor of the fixed 8N1 transmitter on the debug/monitor serial path.
- Adds the following, all set by parameters:
  - configurable baud divisor;
  - configurable data width (5–9 bits);
  - optional odd/even parity;
  - 1 or 2 stop bits;
  - a one-entry holding register with a valid/ready handshake, so frames go out back-to-back with no idle gap.
- Sits between the system-side producer (command/readback logic) and the `rs232_tx` pin.

## Interface
- `BAUD_DIV`, 5208: clock cycles per bit; legal ≥ 2.
- `DATA_BITS`, 8: payload bits per frame; legal 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal 1 or 2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_valid`  in  1  producer offers `tx_data`.
- `tx_ready`  out  1  holding register empty; handshake completes on an edge where `tx_valid && tx_ready`.
- `tx_data`  in  DATA_BITS  payload; sampled only on handshake.
- `tx_busy`  out  1  shifter is sending a frame.
- `tx_done`  out  1  one-cycle pulse at the end of each frame.
- `rs232_tx`  out  1  serial line; registered; idle high.

## Operation
- Reset values:
  - `rs232_tx` = 1, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0.
  - Holding register empty; baud and bit counters 0.
- Frame order, LSB first: start (0), DATA_BITS data bits, parity bit if PARITY≠0, STOP_BITS stop bits (1).
  - Frame length N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- Parity bit:
  - even: XOR of the data bits.
  - odd: the inverse of that XOR.
- `tx_ready` = holding register empty. It is driven from a register, with no combinational path from `tx_valid`.
- The handshake loads the holding register.
- The shifter loads from the holding register when either:
  - the shifter is idle, or
  - the shifter is in the last cycle of the final stop bit.
- The shifter load empties the holding register, so `tx_ready` returns to 1 on the same edge.
- The producer may therefore queue the next word while a frame is in flight.
- Baud counter:
  - counts 0..BAUD_DIV−1 while `tx_busy`;
  - the bit counter advances on wrap, over 0..N−1.
- `rs232_tx` is updated only at bit boundaries: on the shifter load, then on each baud wrap.
- End of frame: on the final baud wrap of bit N−1, `tx_done` pulses.
  - If the holding register is empty: `tx_busy` drops and the line stays high.
  - If it is full: the next start bit begins on that same edge, with zero idle cycles.
- Reset mid-frame:
  - On the next edge the line goes to 1.
  - The frame is abandoned and the held word discarded.
  - No `tx_done` pulse.
- Illegal parameter values are rejected at elaboration by an assertion.

## Timing
- Handshake at edge T (idle shifter, empty holding register):
  - holding register full after T;
  - shifter load at T+1: `rs232_tx` = 0 and `tx_busy` = 1 from T+1.
- Each bit holds for exactly BAUD_DIV cycles.
- `tx_done` is high for the single cycle following the edge at T+1+N·BAUD_DIV.
- Back-to-back: the next start bit begins on that same edge; line period per frame is exactly N·BAUD_DIV.
- Worst-case handshake wait: one full frame, while the holding register is occupied.

## Structure
- Shared package `uart_pkg`:
  - parity encodings `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - function computing frame length N from the parameters;
  - counter-width helpers (`$clog2(BAUD_DIV)`, `$clog2(N)`).
- The package is reused by the companion receiver.
- One sub-module, `uart_baud_gen`:
  - enable input, wrap pulse output, parametrised by BAUD_DIV;
  - synchronous restart on shifter load.
- Holding register, shift register, parity and control stay in the top module.

## Test plan
- 8N1, BAUD_DIV=4, send 0xA5:
  - line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles;
  - `tx_done` pulses once, 41 cycles after the handshake edge;
  - `tx_busy` covers 40 cycles.
- PARITY=2 vs 1, send 0x07:
  - parity bit = 1 (even), 0 (odd);
  - N=11, `tx_done` at handshake+45 with BAUD_DIV=4.
- DATA_BITS=7, STOP_BITS=2, `tx_valid` held high with 0x12 then 0x55:
  - second handshake completes the cycle after the first shifter load;
  - second start bit immediately follows the last stop bit (no gap);
  - two `tx_done` pulses exactly 40 cycles apart.
- Reset asserted mid-data-bit of 0x00 with a word held:
  - `rs232_tx` = 1 and `tx_ready` = 1 next cycle;
  - no `tx_done`;
  - a new handshake then produces a clean frame.
- `tx_valid` asserted while the holding register is full:
  - `tx_ready` stays 0;
  - `tx_data` changes are ignored until ready;
  - the transmitted word matches the value at the handshake edge.
- BAUD_DIV=2, DATA_BITS=9, 0x1FF: frame shows start, nine 1s, stop; 22 cycles total.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and frame/counter sizing helpers.
// Used by both the transmitter and the companion receiver.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int frame_len(int data_bits, int parity, int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

    function automatic int baud_w(int baud_div);
        return $clog2(baud_div);
    endfunction

    function automatic int bit_w(int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the
// last cycle of each bit; restarts from zero when the shifter loads.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic wrap
);

    localparam int CW = baud_w(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // wrap must not depend on restart: the load decision is built from it
    assign wrap = en && (cnt_q == LAST);

    // next count: restart wins, then wrap, then count while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-entry holding register so that
// a queued word starts on the same edge the previous frame ends.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 rs232_tx
);

    localparam int N  = frame_len(DATA_BITS, PARITY, STOP_BITS);
    localparam int BW = bit_w(N);
    localparam int SW = N - 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2)
    begin : g_bad_param
        $error("uart_tx_frame: illegal parameter value");
    end

    logic                 full_q, full_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tx_q, tx_d;
    logic [SW-1:0]        shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;

    logic          wrap;
    logic          last;
    logic          load;
    logic          par;
    logic [SW-1:0] frame;

    uart_baud_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .en     (busy_q),
        .restart(load),
        .wrap   (wrap)
    );

    assign last     = wrap && (bit_q == LAST_BIT);
    assign load     = full_q && (!busy_q || last);
    assign tx_ready = !full_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign rs232_tx = tx_q;

    // bits following the start bit, padded with stop-level ones
    always_comb begin
        par   = (PARITY == PAR_ODD) ? ~(^hold_q) : ^hold_q;
        frame = '1;
        frame[DATA_BITS-1:0] = hold_q;
        if (PARITY != PAR_NONE) begin
            frame[DATA_BITS] = par;
        end
    end

    // handshake, shifter load, bit stepping and end-of-frame control
    always_comb begin
        full_d  = full_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        tx_d    = tx_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        done_d  = last;
        if (tx_valid && !full_q) begin
            full_d = 1'b1;
            hold_d = tx_data;
        end
        if (load) begin
            full_d  = 1'b0;
            busy_d  = 1'b1;
            tx_d    = 1'b0;
            shift_d = frame;
            bit_d   = '0;
        end else if (wrap) begin
            if (last) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
                bit_d  = '0;
            end else begin
                tx_d    = shift_q[0];
                shift_d = {1'b1, shift_q[SW-1:1]};
                bit_d   = bit_q + BW'(1);
            end
        end
    end

    // state registers; reset abandons any frame and the held word
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
            shift_q <= '1;
            bit_q   <= '0;
        end else begin
            full_q  <= full_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five parameter sets against a frame-level
// model, plus hand-computed expectations for each scenario.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] vld, rdy, bsy, dn, line;
    logic [8:0] dat [5];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         chk_en = 0;

    typedef struct {
        int         b, d, p, s, n;
        bit         full;
        logic [8:0] hold;
        bit         busy;
        int         t;
        logic [15:0] bits;
        logic       line, done, rdy;
    } mdl_t;

    mdl_t md [5];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .tx_data(dat[0][7:0]), .tx_busy(bsy[0]), .tx_done(dn[0]),
        .rs232_tx(line[0]));

    uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .tx_data(dat[1][7:0]), .tx_busy(bsy[1]), .tx_done(dn[1]),
        .rs232_tx(line[1]));

    uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_ready(rdy[2]),
        .tx_data(dat[2][7:0]), .tx_busy(bsy[2]), .tx_done(dn[2]),
        .rs232_tx(line[2]));

    uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_ready(rdy[3]),
        .tx_data(dat[3][6:0]), .tx_busy(bsy[3]), .tx_done(dn[3]),
        .rs232_tx(line[3]));

    uart_tx_frame #(.BAUD_DIV(2), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u4 (
        .clk(clk), .rst(rst), .tx_valid(vld[4]), .tx_ready(rdy[4]),
        .tx_data(dat[4]), .tx_busy(bsy[4]), .tx_done(dn[4]),
        .rs232_tx(line[4]));

    // frame-level model: a frame is an N-bit image, line = image[t / BAUD_DIV]
    function automatic mdl_t step(mdl_t m, logic v, logic [8:0] x, logic r);
        mdl_t o = m;
        bit   hs, fin, ld;
        logic p;
        if (r) begin
            o.full = 0; o.busy = 0; o.t = 0;
            o.line = 1'b1; o.done = 1'b0; o.rdy = 1'b1;
            return o;
        end
        hs  = v && !m.full;
        fin = m.busy && (m.t == m.n * m.b - 1);
        ld  = m.full && (!m.busy || fin);
        o.done = fin;
        if (m.busy) o.t = m.t + 1;
        if (fin) o.busy = 0;
        if (ld) begin
            p = 1'b0;
            o.bits = '1;
            o.bits[0] = 1'b0;
            for (int k = 0; k < m.d; k++) begin
                o.bits[1 + k] = m.hold[k];
                p = p ^ m.hold[k];
            end
            if (m.p == 2) o.bits[1 + m.d] = p;
            else if (m.p == 1) o.bits[1 + m.d] = ~p;
            o.busy = 1; o.t = 0; o.full = 0;
        end
        if (hs) begin
            o.full = 1;
            o.hold = x & 9'((1 << m.d) - 1);
        end
        o.rdy  = !o.full;
        o.line = o.busy ? o.bits[o.t / o.b] : 1'b1;
        return o;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) md[i] = step(md[i], vld[i], dat[i], rst);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("line%0d", i), 32'(line[i]), 32'(md[i].line));
            chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(md[i].rdy));
            chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(md[i].busy));
            chk($sformatf("done%0d", i), 32'(dn[i]), 32'(md[i].done));
        end
    endtask

    // called at a negedge; returns at the negedge after the handshake edge
    task automatic send(int i, logic [8:0] x, output int T);
        int w = 0;
        vld[i] = 1'b1;
        dat[i] = x;
        while (!rdy[i] && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!rdy[i]) chk("hs_timeout", 32'(rdy[i]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        T = cyc;
    endtask

    // watch one frame whose start bit begins on edge S
    task automatic observe(int i, int S, int b, int n, output logic [15:0] seen,
                           output int doff, output int dcnt, output int bcnt);
        int off;
        seen = '1; doff = -1; dcnt = 0; bcnt = 0;
        while (cyc < S - 1) @(negedge clk);
        for (int c = 0; c <= n * b; c++) begin
            @(negedge clk);
            off = cyc - S;
            if (off < n * b && off % b == b / 2) seen[off / b] = line[i];
            if (off < n * b && bsy[i]) bcnt++;
            if (dn[i]) begin
                dcnt++;
                doff = off;
            end
        end
    endtask

    initial begin
        int T, T1, T2, doff, dcnt, bcnt, d1, d2, cnt;
        logic [15:0] seen;
        logic l40, l41;
        rst = 1'b1;
        vld = '0;
        for (int i = 0; i < 5; i++) begin
            dat[i] = '0;
            md[i].full = 0; md[i].hold = '0; md[i].busy = 0; md[i].t = 0;
            md[i].bits = '1; md[i].line = 1'b1; md[i].done = 1'b0;
            md[i].rdy = 1'b1;
        end
        md[0].b = 4; md[0].d = 8; md[0].p = 0; md[0].s = 1;
        md[1].b = 4; md[1].d = 8; md[1].p = 2; md[1].s = 1;
        md[2].b = 4; md[2].d = 8; md[2].p = 1; md[2].s = 1;
        md[3].b = 4; md[3].d = 7; md[3].p = 0; md[3].s = 2;
        md[4].b = 2; md[4].d = 9; md[4].p = 0; md[4].s = 1;
        for (int i = 0; i < 5; i++)
            md[i].n = 1 + md[i].d + ((md[i].p != 0) ? 1 : 0) + md[i].s;

        fork
            forever begin
                @(negedge clk);
                if (chk_en) cmp_all();
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_line", 32'(line[0]), 32'd1);
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_done", 32'(dn[0]), 32'd0);
        rst = 1'b0;
        chk_en = 1;
        @(negedge clk);

        // 8N1 0xA5
        send(0, 9'h0A5, T);
        vld[0] = 1'b0;
        observe(0, T + 1, 4, 10, seen, doff, dcnt, bcnt);
        chk("a5_bits", 32'(seen[9:0]), 32'h34A);
        chk("a5_done_lat", doff + 1, 41);
        chk("a5_done_n", dcnt, 1);
        chk("a5_busy", bcnt, 40);

        // even parity 0x07
        send(1, 9'h007, T);
        vld[1] = 1'b0;
        observe(1, T + 1, 4, 11, seen, doff, dcnt, bcnt);
        chk("even_par", 32'(seen[9]), 32'd1);
        chk("even_bits", 32'(seen[10:0]), 32'h60E);
        chk("even_done_lat", doff + 1, 45);

        // odd parity 0x07
        send(2, 9'h007, T);
        vld[2] = 1'b0;
        observe(2, T + 1, 4, 11, seen, doff, dcnt, bcnt);
        chk("odd_par", 32'(seen[9]), 32'd0);
        chk("odd_bits", 32'(seen[10:0]), 32'h40E);
        chk("odd_done_lat", doff + 1, 45);

        // 7 data bits, 2 stops, valid held high: back-to-back frames
        send(3, 9'h012, T1);
        send(3, 9'h055, T2);
        vld[3] = 1'b0;
        chk("b2b_hs", T2 - T1, 2);
        d1 = -1; d2 = -1; l40 = 1'bx; l41 = 1'bx;
        while (cyc < T1 + 95) begin
            @(negedge clk);
            if (dn[3]) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
            if (cyc == T1 + 40) l40 = line[3];
            if (cyc == T1 + 41) l41 = line[3];
        end
        chk("b2b_done1", d1 - T1, 41);
        chk("b2b_gap", d2 - d1, 40);
        chk("b2b_stop", 32'(l40), 32'd1);
        chk("b2b_start", 32'(l41), 32'd0);

        // reset mid data bit with a word held
        send(0, 9'h000, T1);
        send(0, 9'h081, T2);
        vld[0] = 1'b0;
        while (cyc < T1 + 14) @(negedge clk);
        chk("pre_rst_line", 32'(line[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_line", 32'(line[0]), 32'd1);
        chk("mid_rst_ready", 32'(rdy[0]), 32'd1);
        chk("mid_rst_busy", 32'(bsy[0]), 32'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (dn[0]) cnt++;
        end
        chk("rst_no_done", cnt, 0);
        send(0, 9'h03C, T);
        vld[0] = 1'b0;
        observe(0, T + 1, 4, 10, seen, doff, dcnt, bcnt);
        chk("clean_bits", 32'(seen[9:0]), 32'h278);
        chk("clean_done_n", dcnt, 1);

        // valid while holding register full; data changes ignored
        send(0, 9'h011, T1);
        send(0, 9'h022, T2);
        dat[0] = 9'h033;
        cnt = 0;
        while (cyc < T1 + 41) begin
            if (rdy[0]) cnt++;
            @(negedge clk);
            dat[0] = dat[0] + 9'h001;
        end
        chk("full_ready_lo", cnt, 0);
        chk("full_ready_up", 32'(rdy[0]), 32'd1);
        dat[0] = 9'h066;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        dat[0] = 9'h0FF;
        observe(0, T1 + 81, 4, 10, seen, doff, dcnt, bcnt);
        chk("full_word", 32'(seen[9:0]), 32'h2CC);

        // 9 data bits at BAUD_DIV=2
        send(4, 9'h1FF, T);
        vld[4] = 1'b0;
        observe(4, T + 1, 2, 11, seen, doff, dcnt, bcnt);
        chk("w9_bits", 32'(seen[10:0]), 32'h7FE);
        chk("w9_busy", bcnt, 22);
        chk("w9_done_lat", doff + 1, 23);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
